// File: rtl/clk_ratio_mon_pkg.sv
// Shared types and helpers for the divided-clock ratio monitor.
package clk_ratio_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEAS_HI = 2'd2,
    MEAS_LO = 2'd3
  } mon_state_t;

  function automatic int unsigned sat_val(input int unsigned width);
    return (2 ** width) - 1;
  endfunction

endpackage

// File: rtl/clk_ratio_mon_edge.sv
// Samples the monitored clock as data and flags its rising/falling edges.
// CLK_RATIO_MON_SYNC_EN adds a 2-flop synchronizer ahead of the sample flop.
module clk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic mon_clk,
  output logic s,
  output logic rise,
  output logic fall
);

  logic din;
  logic samp, samp_q, rise_q, fall_q;

`ifdef CLK_RATIO_MON_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], mon_clk};
  end
  assign din = sync[1];
`else
  assign din = mon_clk;
`endif

  // Edge flags are registered; s is taken from samp_q so level and edges stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp   <= 1'b0;
      samp_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      samp   <= din;
      samp_q <= samp;
      rise_q <= samp & ~samp_q;
      fall_q <= ~samp & samp_q;
    end
  end

  assign s    = samp_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clk_ratio_mon.sv
// Measures the period of a divided clock in reference cycles and reports lock/mismatch/stuck.
// Optional build macro: CLK_RATIO_MON_SYNC_EN (synchronizer for asynchronous monitored clocks).
module clk_ratio_mon
  import clk_ratio_mon_pkg::*;
#(
  parameter int RATIO_WD = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                i_mon_en,
  input  logic                i_mon_clk,
  input  logic [RATIO_WD-1:0] i_exp_ratio,
  output logic [RATIO_WD-1:0] o_ratio,
  output logic                o_ratio_vld,
  output logic                o_locked,
  output logic                o_mismatch,
  output logic                o_stuck
);

  localparam int unsigned         SAT_I = sat_val(RATIO_WD);
  localparam logic [RATIO_WD-1:0] SAT   = SAT_I[RATIO_WD-1:0];
  localparam logic [3:0]          LC    = 4'(LOCK_CNT);

  logic s, rise, fall;

  clk_edge_det u_edge (
    .clk     (i_ref_clk),
    .rst     (i_rst),
    .mon_clk (i_mon_clk),
    .s       (s),
    .rise    (rise),
    .fall    (fall)
  );

  mon_state_t          state, state_n;
  logic [RATIO_WD-1:0] hi_cnt, hi_n, lo_cnt, lo_n, ratio_n;
  logic [3:0]          match, match_n, match_inc;
  logic                vld_n, mism_n, locked_n, stuck_n;
  logic [RATIO_WD:0]   sum;
  logic [RATIO_WD-1:0] meas;
  logic                cmp_en;

  assign sum       = {1'b0, hi_cnt} + {1'b0, lo_cnt};
  assign meas      = (sum > {1'b0, SAT}) ? SAT : sum[RATIO_WD-1:0];
  assign cmp_en    = (i_exp_ratio > RATIO_WD'(1));
  assign match_inc = (match < LC) ? match + 4'd1 : match;

  always_comb begin
    state_n  = state;
    hi_n     = hi_cnt;
    lo_n     = lo_cnt;
    ratio_n  = o_ratio;
    vld_n    = 1'b0;
    mism_n   = 1'b0;
    locked_n = o_locked;
    stuck_n  = o_stuck;
    match_n  = match;
    if (!i_mon_en) begin
      state_n  = IDLE;
      hi_n     = '0;
      lo_n     = '0;
      match_n  = '0;
      locked_n = 1'b0;
      stuck_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: state_n = SEEK;
        SEEK: begin
          if (rise) begin
            state_n = MEAS_HI;
            hi_n    = RATIO_WD'(1);
            lo_n    = '0;
          end
        end
        MEAS_HI, MEAS_LO: begin
          // A saturated counter means no toggle for SAT cycles: abandon the period.
          if (hi_cnt == SAT || lo_cnt == SAT) begin
            state_n  = SEEK;
            hi_n     = '0;
            lo_n     = '0;
            stuck_n  = 1'b1;
            locked_n = 1'b0;
            match_n  = '0;
          end else if (state == MEAS_HI) begin
            if (fall) begin
              state_n = MEAS_LO;
              lo_n    = RATIO_WD'(1);
            end else if (s) begin
              hi_n = hi_cnt + RATIO_WD'(1);
            end
          end else if (rise) begin
            state_n = MEAS_HI;
            hi_n    = RATIO_WD'(1);
            lo_n    = '0;
            ratio_n = meas;
            vld_n   = 1'b1;
            stuck_n = 1'b0;
            if (!cmp_en) begin
              match_n  = '0;
              locked_n = 1'b0;
            end else if (meas == i_exp_ratio) begin
              match_n  = match_inc;
              locked_n = (match_inc == LC);
            end else begin
              mism_n   = 1'b1;
              match_n  = '0;
              locked_n = 1'b0;
            end
          end else if (!s) begin
            lo_n = lo_cnt + RATIO_WD'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      hi_cnt      <= '0;
      lo_cnt      <= '0;
      match       <= '0;
      o_ratio     <= '0;
      o_ratio_vld <= 1'b0;
      o_mismatch  <= 1'b0;
      o_locked    <= 1'b0;
      o_stuck     <= 1'b0;
    end else begin
      state       <= state_n;
      hi_cnt      <= hi_n;
      lo_cnt      <= lo_n;
      match       <= match_n;
      o_ratio     <= ratio_n;
      o_ratio_vld <= vld_n;
      o_mismatch  <= mism_n;
      o_locked    <= locked_n;
      o_stuck     <= stuck_n;
    end
  end

endmodule

// File: tb/tb_clk_ratio_mon.sv
// Directed bench for clk_ratio_mon: lock, mismatch, stuck, abort and boundary ratios.
module tb_clk_ratio_mon;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_mon_en = 1'b0;
  logic       i_mon_clk = 1'b0;
  logic [7:0] i_exp_ratio = 8'd4;
  logic [7:0] o_ratio;
  logic       o_ratio_vld, o_locked, o_mismatch, o_stuck;

  int errors = 0;
  int checks = 0;
  int pulses, bad_ratio, bad_phase, mism, lock_at, stuck_seen, stuck_vld1;

  always #5 clk = ~clk;

  clk_ratio_mon dut (
    .i_ref_clk   (clk),
    .i_rst       (i_rst),
    .i_mon_en    (i_mon_en),
    .i_mon_clk   (i_mon_clk),
    .i_exp_ratio (i_exp_ratio),
    .o_ratio     (o_ratio),
    .o_ratio_vld (o_ratio_vld),
    .o_locked    (o_locked),
    .o_mismatch  (o_mismatch),
    .o_stuck     (o_stuck)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic m);
    i_mon_clk = m;
    @(posedge clk);
    #1;
  endtask

  // Drives n periods of hi/lo cycles; a pulse must land 2 cycles after each sampled rise.
  task automatic drive(input int hi, input int lo, input int n, input int er);
    int per = hi + lo;
    int t = 0;
    pulses = 0; bad_ratio = 0; bad_phase = 0; mism = 0;
    lock_at = 0; stuck_seen = 0; stuck_vld1 = -1;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < per; c++) begin
        tick(c < hi);
        if (o_stuck) stuck_seen++;
        if (o_mismatch && !o_ratio_vld) bad_phase++;
        if (o_ratio_vld) begin
          pulses++;
          if (int'(o_ratio) != er) bad_ratio++;
          if ((t % per) != (2 % per)) bad_phase++;
          if (o_mismatch) mism++;
          if (o_mismatch && o_locked) bad_phase++;
          if (o_locked && lock_at == 0) lock_at = pulses;
          if (pulses == 1) stuck_vld1 = int'(o_stuck);
        end
        t++;
      end
    end
  endtask

  initial begin
    int vld_cnt;
    int stuck_first;

    // Reset state
    repeat (3) tick(1'b0);
    chk("rst_ratio",    int'(o_ratio), 0);
    chk("rst_vld",      int'(o_ratio_vld), 0);
    chk("rst_locked",   int'(o_locked), 0);
    chk("rst_mismatch", int'(o_mismatch), 0);
    chk("rst_stuck",    int'(o_stuck), 0);

    // Ratio 4, expected 4
    i_rst = 1'b0; i_mon_en = 1'b1; i_exp_ratio = 8'd4;
    tick(1'b0); tick(1'b0);
    drive(2, 2, 6, 4);
    chk("r4_pulses",    pulses, 5);
    chk("r4_ratio",     bad_ratio, 0);
    chk("r4_phase",     bad_phase, 0);
    chk("r4_lock_at",   lock_at, 4);
    chk("r4_mismatch",  mism, 0);
    chk("r4_locked",    int'(o_locked), 1);
    chk("r4_stuck",     stuck_seen, 0);

    // Expected ratio changes to 6 while locked
    i_exp_ratio = 8'd6;
    drive(2, 2, 1, 4);
    chk("chg_pulses",   pulses, 1);
    chk("chg_mismatch", mism, 1);
    chk("chg_phase",    bad_phase, 0);
    chk("chg_locked",   int'(o_locked), 0);

    // Disable/enable, then ratio 5 (2 high, 3 low)
    i_mon_en = 1'b0;
    tick(1'b0);
    chk("dis_vld",      int'(o_ratio_vld), 0);
    chk("dis_mismatch", int'(o_mismatch), 0);
    chk("dis_ratio",    int'(o_ratio), 4);
    tick(1'b0);
    i_mon_en = 1'b1; i_exp_ratio = 8'd5;
    tick(1'b0);
    drive(2, 3, 6, 5);
    chk("r5_pulses",    pulses, 5);
    chk("r5_ratio",     bad_ratio, 0);
    chk("r5_phase",     bad_phase, 0);
    chk("r5_lock_at",   lock_at, 4);
    chk("r5_mismatch",  mism, 0);

    // Enable dropped mid-period
    tick(1'b1); tick(1'b1);
    i_mon_en = 1'b0;
    tick(1'b1);
    chk("ab_vld",       int'(o_ratio_vld), 0);
    chk("ab_locked",    int'(o_locked), 0);
    chk("ab_mismatch",  int'(o_mismatch), 0);
    chk("ab_stuck",     int'(o_stuck), 0);
    chk("ab_ratio",     int'(o_ratio), 5);
    tick(1'b0);
    i_mon_en = 1'b1; i_exp_ratio = 8'd4;
    tick(1'b0);
    drive(2, 2, 3, 4);
    chk("ab_re_pulses", pulses, 2);
    chk("ab_re_ratio",  bad_ratio, 0);
    chk("ab_re_phase",  bad_phase, 0);

    // Reset mid-period
    tick(1'b1); tick(1'b1);
    i_rst = 1'b1;
    tick(1'b1);
    chk("mr_ratio",     int'(o_ratio), 0);
    chk("mr_vld",       int'(o_ratio_vld), 0);
    chk("mr_locked",    int'(o_locked), 0);
    chk("mr_stuck",     int'(o_stuck), 0);
    i_rst = 1'b0;
    tick(1'b0);
    drive(2, 2, 3, 4);
    chk("mr_re_pulses", pulses, 2);
    chk("mr_re_ratio",  bad_ratio, 0);

    // Monitored clock stuck high for 300 cycles
    i_mon_en = 1'b0; tick(1'b0);
    i_mon_en = 1'b1; tick(1'b0);
    vld_cnt = 0; stuck_first = -1;
    for (int k = 0; k < 300; k++) begin
      tick(1'b1);
      if (o_ratio_vld) vld_cnt++;
      if (o_stuck && stuck_first < 0) stuck_first = k;
    end
    chk("st_vld",       vld_cnt, 0);
    chk("st_latency",   int'(stuck_first >= 254 && stuck_first <= 258), 1);
    chk("st_stuck",     int'(o_stuck), 1);
    chk("st_locked",    int'(o_locked), 0);
    tick(1'b0); tick(1'b0);
    chk("st_hold",      int'(o_stuck), 1);
    drive(2, 2, 3, 4);
    chk("st_re_pulses", pulses, 2);
    chk("st_clr_first", stuck_vld1, 0);
    chk("st_re_ratio",  bad_ratio, 0);

    // Minimum ratio 2
    i_mon_en = 1'b0; tick(1'b0);
    i_mon_en = 1'b1; i_exp_ratio = 8'd2; tick(1'b0);
    drive(1, 1, 6, 2);
    chk("r2_pulses",    pulses, 4);
    chk("r2_ratio",     bad_ratio, 0);
    chk("r2_phase",     bad_phase, 0);
    chk("r2_lock_at",   lock_at, 4);
    chk("r2_stuck",     stuck_seen, 0);

    // Maximum ratio 255 with comparison bypassed (expected ratio 0)
    i_mon_en = 1'b0; tick(1'b0); tick(1'b0);
    i_mon_en = 1'b1; i_exp_ratio = 8'd0; tick(1'b0);
    drive(128, 127, 3, 255);
    chk("r255_pulses",  pulses, 2);
    chk("r255_ratio",   bad_ratio, 0);
    chk("r255_phase",   bad_phase, 0);
    chk("r255_stuck",   stuck_seen, 0);
    chk("r255_mism",    mism, 0);
    chk("r255_lock",    lock_at, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
